mc_main_ctrl: RTL and testbench
===============================

# mc_main_ctrl

Multi-cycle main control FSM for the MIPS32 datapath. It sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives the 2-bit `ALUOp` code into the ALU control decoder and every datapath enable and mux select. Memory accesses stall on a ready handshake, and unsupported opcodes are flagged and skipped.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `op`  in  6  opcode field `IR[31:26]`. Sampled only in DECODE.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load qualified by ALU zero (beq).
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `IRWrite`  out  1  instruction register load.
- `MemtoReg`  out  1  write-back data select: 0 = ALUOut, 1 = MDR.
- `RegDst`  out  1  destination register select: 0 = rt, 1 = rd.
- `RegWrite`  out  1  register file write.
- `ALUSrcA`  out  1  ALU A operand: 0 = PC, 1 = A register.
- `ALUSrcB`  out  2  ALU B operand: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp`  out  2  00 = add, 01 = subtract, 10 = use func field.
- `PCSource`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse when an unsupported opcode is decoded.
- `state`  out  4  current state, for debug.

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5.
  - EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, IWB = 11.
  - Codes 12–15 are unreachable. If reached, the next state is FETCH.
- Outputs are decoded from the state register. Only the outputs marked "gated by `mem_ready`" also depend on `mem_ready`. Any output not listed for a state is 0.
- FETCH
  - Fixed outputs: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00, `PCSource`=00.
  - `IRWrite` and `PCWrite` are gated by `mem_ready`.
  - Next state: DECODE if `mem_ready`, else stay in FETCH.
- DECODE
  - Outputs: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=00 (computes the branch target).
  - Next state by opcode:
    - 0x00 → EXEC
    - 0x23 (lw) → MEMADR
    - 0x2B (sw) → MEMADR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - 0x08 → ADDIEX
    - any other → FETCH, with `illegal_op`=1 for this cycle.
- MEMADR
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
  - Next state: MEMRD for lw, MEMWR for sw. The opcode is held in a register captured in DECODE.
- MEMRD
  - Outputs: `MemRead`=1, `IorD`=1.
  - Next state: MEMWB if `mem_ready`, else stay.
- MEMWB
  - Outputs: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0.
  - Next state: FETCH.
- MEMWR
  - Outputs: `MemWrite`=1, `IorD`=1.
  - Next state: FETCH if `mem_ready`, else stay.
  - `MemWrite` stays asserted for every stall cycle.
- EXEC
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10.
  - Next state: RWB.
- RWB
  - Outputs: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0.
  - Next state: FETCH.
- BRANCH
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=01.
  - Next state: FETCH.
- JUMP
  - Outputs: `PCWrite`=1, `PCSource`=10.
  - Next state: FETCH.
- ADDIEX
  - Outputs: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00.
  - Next state: IWB.
- IWB
  - Outputs: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0.
  - Next state: FETCH.
- `illegal_op` is registered: it is high for exactly the one cycle after the DECODE cycle that saw the bad opcode, which is the first FETCH cycle.

## Timing
- Reset
  - `rst`=1 forces `state`=FETCH immediately, without waiting for a clock edge.
  - The captured opcode register resets to 0, and `illegal_op` resets to 0.
  - Output values during reset:
    - `MemRead`=1, `ALUSrcB`=01.
    - `IRWrite` and `PCWrite` equal `mem_ready`.
    - All other outputs are 0.
  - `rst` asserted mid-instruction abandons it. No partial `RegWrite` or `MemWrite` is issued after reset asserts.
- Cycle counts with `mem_ready` held at 1, counted FETCH to FETCH:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Every other output is held stable during the stall.
- `op` is don't-care in every state except DECODE.

## Test plan
- Reset behaviour: assert `rst` while in MEMWR with `MemWrite`=1 → `state`=0 and `MemWrite`=0 in the same cycle, before any clock edge.
- R-type: `op`=0x00, `mem_ready`=1 → states 0, 1, 6, 7, 0. `ALUOp`=10 in EXEC. `RegWrite`=1 and `RegDst`=1 only in RWB.
- lw with stall: `op`=0x23, `mem_ready`=0 for the first 2 cycles of MEMRD → sequence is 0, 1, 2, 3, 3, 3, 4, 0. `MemtoReg`=1 in MEMWB.
- sw: `op`=0x2B → sequence 0, 1, 2, 5, 0. `MemWrite`=1 for exactly one cycle. `RegWrite` is never 1.
- Branch and jump: beq gives `ALUOp`=01 with `PCWriteCond`=1 for one cycle. j gives `PCWrite`=1 with `PCSource`=10. Each instruction takes 3 cycles.
- Illegal opcode: `op`=0x3F → DECODE goes to FETCH. `illegal_op` pulses high for exactly 1 cycle. No `RegWrite`, `MemWrite` or `PCWriteCond` is issued.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control FSM for a MIPS32 datapath: sequences fetch, decode,
// execute, memory and write-back cycles and drives every datapath control.
module mc_main_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_IWB    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic       illegal_q, illegal_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Memory handshake: a request (MemRead/MemWrite) is held with all other
    // controls stable until mem_ready is seen high in the same cycle; that
    // cycle completes the access and the FSM advances on the next edge.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = op;
                case (op)
                    OP_RTYPE: state_d = S_EXEC;
                    OP_LW:    state_d = S_MEMADR;
                    OP_SW:    state_d = S_MEMADR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    OP_ADDI:  state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:   state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ADDIEX: state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_IWB:    RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: directed instructions, randomized
// instruction stream with random stalls, and asynchronous reset mid-store.
module tb_mc_main_ctrl;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
  localparam int EXEC = 6, RWB = 7, BRANCH = 8, JUMP = 9, ADDIEX = 10, IWB = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  bit prev_ill = 1'b0;

  // Each step: {op[5:0], state[3:0], mem_ready}
  logic [10:0] exp_q[$];

  mc_main_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return (o == 6'h00) || (o == 6'h23) || (o == 6'h2B) ||
           (o == 6'h04) || (o == 6'h02) || (o == 6'h08);
  endfunction

  // Control word {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,
  // RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSource} expected in a given state.
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aop, pcs;
    pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; m2r = 0;
    rdst = 0; rw = 0; srca = 0; srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      FETCH:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      DECODE: srcb = 2'b11;
      MEMADR: begin srca = 1; srcb = 2'b10; end
      MEMRD:  begin mrd = 1; iord = 1; end
      MEMWB:  begin rw = 1; m2r = 1; end
      MEMWR:  begin mwr = 1; iord = 1; end
      EXEC:   begin srca = 1; aop = 2'b10; end
      RWB:    begin rw = 1; rdst = 1; end
      BRANCH: begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      JUMP:   begin pcw = 1; pcs = 2'b10; end
      ADDIEX: begin srca = 1; srcb = 2'b10; end
      IWB:    rw = 1;
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, pcs};
  endfunction

  function automatic logic [15:0] act_ctrl();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
  endfunction

  task automatic push(input logic [5:0] o, input int st, input logic mr);
    exp_q.push_back({o, st[3:0], mr});
  endtask

  // Expected state walk of one instruction, FETCH through its last state.
  task automatic build(input logic [5:0] o, input int fs, input int ms);
    for (int i = 0; i < fs; i++) push(6'h0, FETCH, 1'b0);
    push(6'h0, FETCH, 1'b1);
    push(o, DECODE, 1'($urandom_range(0, 1)));
    case (o)
      6'h00: begin push(o, EXEC, 1'($urandom_range(0, 1))); push(o, RWB, 1'($urandom_range(0, 1))); end
      6'h23: begin
        push(o, MEMADR, 1'($urandom_range(0, 1)));
        for (int i = 0; i < ms; i++) push(o, MEMRD, 1'b0);
        push(o, MEMRD, 1'b1);
        push(o, MEMWB, 1'($urandom_range(0, 1)));
      end
      6'h2B: begin
        push(o, MEMADR, 1'($urandom_range(0, 1)));
        for (int i = 0; i < ms; i++) push(o, MEMWR, 1'b0);
        push(o, MEMWR, 1'b1);
      end
      6'h04: push(o, BRANCH, 1'($urandom_range(0, 1)));
      6'h02: push(o, JUMP, 1'($urandom_range(0, 1)));
      6'h08: begin push(o, ADDIEX, 1'($urandom_range(0, 1))); push(o, IWB, 1'($urandom_range(0, 1))); end
      default: ;
    endcase
  endtask

  // Called just after a rising edge; drives one cycle, checks it at the falling edge.
  task automatic run(input int max_steps);
    logic [10:0] e;
    int n;
    string tag;
    n = 0;
    while (exp_q.size() > 0 && n < max_steps) begin
      e = exp_q.pop_front();
      n++;
      op = (int'(e[4:1]) == DECODE) ? e[10:5] : 6'($urandom);
      mem_ready = e[0];
      @(negedge clk);
      tag = $sformatf("st%0d_mr%0d", e[4:1], e[0]);
      chk({tag, "_state"}, 32'(state), 32'(e[4:1]));
      chk({tag, "_ctrl"}, 32'(act_ctrl()), 32'(exp_ctrl(int'(e[4:1]), e[0])));
      chk({tag, "_illegal"}, 32'(illegal_op), 32'(prev_ill));
      prev_ill = (int'(e[4:1]) == DECODE) && !is_legal(e[10:5]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] o;
    int k;
    rst = 1'b1;
    op = 6'h00;
    mem_ready = 1'b0;
    #2;
    chk("rst_state", 32'(state), FETCH);
    chk("rst_ctrl_mr0", 32'(act_ctrl()), 32'(exp_ctrl(FETCH, 1'b0)));
    chk("rst_illegal", 32'(illegal_op), 0);
    mem_ready = 1'b1;
    #1;
    chk("rst_ctrl_mr1", 32'(act_ctrl()), 32'(exp_ctrl(FETCH, 1'b1)));
    @(posedge clk);
    #1;
    chk("rst_hold_state", 32'(state), FETCH);
    rst = 1'b0;

    // Directed: R-type, lw with 2 stall cycles, sw, beq, j, illegal, addi.
    build(6'h00, 0, 0);
    build(6'h23, 0, 2);
    build(6'h2B, 0, 0);
    build(6'h04, 0, 0);
    build(6'h02, 0, 0);
    build(6'h3F, 0, 0);
    build(6'h08, 0, 0);
    build(6'h00, 1, 0);
    run(1000);

    // Randomized instruction stream with random fetch and memory stalls.
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: o = 6'h00;
        1: o = 6'h23;
        2: o = 6'h2B;
        3: o = 6'h04;
        4: o = 6'h02;
        5: o = 6'h08;
        default: begin
          o = 6'($urandom_range(0, 63));
          if (is_legal(o)) o = 6'h3F;
        end
      endcase
      build(o, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run(100000);

    // Reset asserted while a store is stalled in MEMWR.
    build(6'h2B, 0, 4);
    run(4);
    exp_q.delete();
    mem_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_memwr_state", 32'(state), MEMWR);
    chk("pre_rst_memwrite", 32'(MemWrite), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), FETCH);
    chk("async_rst_memwrite", 32'(MemWrite), 0);
    chk("async_rst_ctrl", 32'(act_ctrl()), 32'(exp_ctrl(FETCH, 1'b0)));
    @(posedge clk);
    #1;
    chk("rst_held_memwrite", 32'(MemWrite), 0);
    chk("rst_held_regwrite", 32'(RegWrite), 0);
    rst = 1'b0;
    prev_ill = 1'b0;
    build(6'h23, 0, 0);
    build(6'h2B, 0, 1);
    run(1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
